// File: rtl/eth_sw_pkg.sv
// Shared switch definitions: FIFO word layout {data[31:0], start, end} and arbiter states.
package eth_sw_pkg;

  localparam int FIFO_W    = 34;
  localparam int DATA_W    = 32;
  localparam int END_BIT   = 0;
  localparam int START_BIT = 1;
  localparam int DATA_LSB  = 2;
  localparam int CNT_W     = 16;

  typedef enum logic {
    IDLE,
    FWD
  } arb_state_e;

  // Index/field width for n items, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/eth_out_arb_if.sv
// Egress arbiter bundle: per-ingress show-ahead FIFO read side plus the registered egress port.
interface eth_out_arb_if #(
  parameter int N_IN = 2
) ();
  import eth_sw_pkg::*;

  logic [N_IN-1:0][FIFO_W-1:0] fifo_rd_data;
  logic [N_IN-1:0]             fifo_empty;
  logic [N_IN-1:0]             fifo_rd_en;
  logic [DATA_W-1:0]           o_data;
  logic                        o_start;
  logic                        o_end;
  logic                        o_valid;
  logic                        o_ready;

  modport master (
    input  fifo_rd_data, fifo_empty, o_ready,
    output fifo_rd_en, o_data, o_start, o_end, o_valid
  );

  modport slave (
    output fifo_rd_data, fifo_empty, o_ready,
    input  fifo_rd_en, o_data, o_start, o_end, o_valid
  );

endinterface

// File: rtl/eth_out_arb_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after i_rr_ptr, wrapping modulo N.
module rr_arbiter
  import eth_sw_pkg::*;
#(
  parameter  int N  = 2,
  localparam int PW = idx_w(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_rr_ptr,
  output logic [PW-1:0] o_grant,
  output logic          o_grant_vld
);

  int w_dist;
  int w_best;

  // Winner is the requester with the smallest forward distance from the pointer.
  always_comb begin
    o_grant     = '0;
    o_grant_vld = 1'b0;
    w_dist      = 0;
    w_best      = N;
    for (int j = 0; j < N; j++) begin
      w_dist = (j + N - int'(i_rr_ptr)) % N;
      if (i_req[j] && (w_dist < w_best)) begin
        w_best      = w_dist;
        o_grant     = PW'(j);
        o_grant_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/eth_out_arb.sv
// Egress arbiter: picks an ingress packet by destination + round-robin, drains it atomically (2-cycle latency).
// Stalls pops while o_valid && !o_ready; optional per-input packet counters under ETH_OUT_ARB_PKT_CNT_EN.
module eth_out_arb
  import eth_sw_pkg::*;
#(
  parameter int N_IN     = 2,
  parameter int PORT_ID  = 0,
  parameter int DEST_LSB = 0
) (
  input  logic clk,
  input  logic rstn,
  eth_out_arb_if.master bus
`ifdef ETH_OUT_ARB_PKT_CNT_EN
  ,
  output logic [N_IN-1:0][CNT_W-1:0] pkt_cnt
`endif
);

  localparam int PW = idx_w(N_IN);
  localparam int DW = idx_w(N_IN);

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  logic [PW-1:0]     r_grant;
  logic [PW-1:0]     w_grant_nxt;
  logic [PW-1:0]     r_rr_ptr;
  logic [PW-1:0]     w_rr_nxt;
  logic [DATA_W-1:0] r_data;
  logic              r_start;
  logic              r_end;
  logic              r_valid;

  logic [N_IN-1:0]   w_req;
  logic [N_IN-1:0]   w_rd_en;
  logic [PW-1:0]     w_arb_grant;
  logic              w_arb_vld;
  logic [FIFO_W-1:0] w_head;
  logic              w_pop;
  logic              w_pkt_done;

  // Continuation words (start=0) never request: they belong to a packet another egress owns.
  for (genvar gi = 0; gi < N_IN; gi++) begin : g_req
    assign w_req[gi] = !bus.fifo_empty[gi]
                       && bus.fifo_rd_data[gi][START_BIT]
                       && (bus.fifo_rd_data[gi][DATA_LSB+DEST_LSB +: DW] == DW'(PORT_ID));
  end

  rr_arbiter #(
    .N (N_IN)
  ) u_rr_arbiter (
    .i_req       (w_req),
    .i_rr_ptr    (r_rr_ptr),
    .o_grant     (w_arb_grant),
    .o_grant_vld (w_arb_vld)
  );

  assign w_head     = bus.fifo_rd_data[r_grant];
  assign w_pkt_done = w_pop && w_head[END_BIT];

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_rr_nxt    = r_rr_ptr;
    w_pop       = 1'b0;
    w_rd_en     = '0;
    case (r_state)
      IDLE: begin
        if (w_arb_vld) begin
          w_grant_nxt = w_arb_grant;
          w_state_nxt = FWD;
        end
      end
      FWD: begin
        w_pop            = !bus.fifo_empty[r_grant] && (!r_valid || bus.o_ready);
        w_rd_en[r_grant] = w_pop;
        if (w_pkt_done) begin
          w_state_nxt = IDLE;
          w_rr_nxt    = (int'(r_grant) == N_IN - 1) ? '0 : r_grant + PW'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_rr_ptr <= w_rr_nxt;
    end
  end

  // The last word of a packet may still be waiting for o_ready after FSM has returned to IDLE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_data  <= '0;
      r_start <= 1'b0;
      r_end   <= 1'b0;
      r_valid <= 1'b0;
    end else if (w_pop) begin
      r_data  <= w_head[DATA_LSB +: DATA_W];
      r_start <= w_head[START_BIT];
      r_end   <= w_head[END_BIT];
      r_valid <= 1'b1;
    end else if (bus.o_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.fifo_rd_en = w_rd_en;
  assign bus.o_data     = r_data;
  assign bus.o_start    = r_start;
  assign bus.o_end      = r_end;
  assign bus.o_valid    = r_valid;

`ifdef ETH_OUT_ARB_PKT_CNT_EN
  logic [N_IN-1:0][CNT_W-1:0] r_pkt_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pkt_cnt <= '0;
    end else if (w_pkt_done) begin
      r_pkt_cnt[r_grant] <= r_pkt_cnt[r_grant] + CNT_W'(1);
    end
  end

  assign pkt_cnt = r_pkt_cnt;
`endif

  a_rd_en_onehot : assert property (@(posedge clk) disable iff (!rstn) $onehot0(bus.fifo_rd_en));

  a_stall_hold : assert property (@(posedge clk) disable iff (!rstn)
    (r_valid && !bus.o_ready) |=> (r_valid && $stable(r_data)));

endmodule

// File: tb/tb_eth_out_arb.sv
// Self-checking bench for eth_out_arb: queue-based FIFO model, packet-level round-robin scoreboard.
module tb_eth_out_arb;
  import eth_sw_pkg::*;

  localparam int N_IN     = 2;
  localparam int PORT_ID  = 0;
  localparam int DEST_LSB = 0;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  eth_out_arb_if #(.N_IN(N_IN)) bus ();
`ifdef ETH_OUT_ARB_PKT_CNT_EN
  logic [N_IN-1:0][15:0] pkt_cnt;
`endif

  eth_out_arb #(
    .N_IN     (N_IN),
    .PORT_ID  (PORT_ID),
    .DEST_LSB (DEST_LSB)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
`ifdef ETH_OUT_ARB_PKT_CNT_EN
    ,
    .pkt_cnt (pkt_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int stall_bad = 0;
  int underflow = 0;
  int model_rr = 0;
  logic [33:0] fq [N_IN][$];
  logic [33:0] got_q [$];
  int          got_t [$];
  logic [33:0] exp_q [$];

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic drive_inputs();
    for (int i = 0; i < N_IN; i++) begin
      bus.fifo_empty[i]   = (fq[i].size() == 0);
      bus.fifo_rd_data[i] = (fq[i].size() != 0) ? fq[i][0] : 34'h0;
    end
  endtask

  // One clock: record accepted egress word, pop FIFOs the DUT strobed, re-drive heads.
  task automatic cycle();
    logic [N_IN-1:0] pops;
    logic            stall;
    logic [31:0]     held;
    #1;
    pops  = bus.fifo_rd_en;
    stall = bus.o_valid && !bus.o_ready;
    held  = bus.o_data;
    if (bus.o_valid && bus.o_ready) begin
      got_q.push_back({bus.o_data, bus.o_start, bus.o_end});
      got_t.push_back(cyc);
    end
    @(posedge clk);
    cyc++;
    for (int i = 0; i < N_IN; i++) begin
      if (pops[i]) begin
        if (fq[i].size() == 0) underflow++;
        else fq[i].delete(0);
      end
    end
    @(negedge clk);
    drive_inputs();
    #1;
    if (stall && (!bus.o_valid || bus.o_data !== held)) stall_bad++;
  endtask

  task automatic push_pkt(input int f, input int len, input logic [31:0] base, input logic dest);
    logic [31:0] d;
    for (int k = 0; k < len; k++) begin
      d = base + 32'(k * 16);
      d[DEST_LSB] = dest;
      fq[f].push_back({d, (k == 0), (k == len - 1)});
    end
    drive_inputs();
  endtask

  // Packet-level reference: every queued packet requests; winner is first non-empty FIFO from model_rr.
  task automatic build_expected();
    logic [33:0] m [N_IN][$];
    logic [33:0] w;
    int src;
    logic more;
    exp_q.delete();
    for (int i = 0; i < N_IN; i++) m[i] = fq[i];
    more = 1'b1;
    while (more) begin
      src = -1;
      for (int k = N_IN - 1; k >= 0; k--)
        if (m[(model_rr + k) % N_IN].size() != 0) src = (model_rr + k) % N_IN;
      if (src < 0) more = 1'b0;
      else begin
        w = '0;
        while (!w[0] && m[src].size() != 0) begin
          w = m[src].pop_front();
          exp_q.push_back(w);
        end
        model_rr = (src + 1) % N_IN;
      end
    end
  endtask

  task automatic run_drain(input int max_cycles, input logic rnd, output logic timed_out);
    int n;
    int idle;
    logic all_empty;
    n = 0;
    idle = 0;
    timed_out = 1'b0;
    while (idle < 3 && !timed_out) begin
      if (n >= max_cycles) timed_out = 1'b1;
      else begin
        if (rnd) bus.o_ready = ($urandom_range(0, 3) != 0);
        cycle();
        n++;
        all_empty = 1'b1;
        for (int i = 0; i < N_IN; i++) if (fq[i].size() != 0) all_empty = 1'b0;
        if (all_empty && !bus.o_valid) idle++;
        else idle = 0;
      end
    end
  endtask

  task automatic clear_capture();
    got_q.delete();
    got_t.delete();
    stall_bad = 0;
    underflow = 0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    for (int i = 0; i < N_IN; i++) fq[i].delete();
    drive_inputs();
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    model_rr = 0;
    clear_capture();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    bus.o_ready = 1'b1;
    push_pkt(0, 2, 32'h100, 1'(PORT_ID));
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checks++; if (bus.o_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.o_valid);
    checks++; if (bus.o_data !== 32'h0) $display("FAIL reset_data: got %h want 0", bus.o_data);
    checks++; if (bus.o_start !== 1'b0) $display("FAIL reset_start: got %b want 0", bus.o_start);
    checks++; if (bus.o_end !== 1'b0) $display("FAIL reset_end: got %b want 0", bus.o_end);
    checks++; if (bus.fifo_rd_en !== 2'b00) $display("FAIL reset_rd_en: got %b want 00", bus.fifo_rd_en);
    errors += (bus.o_valid !== 1'b0) + (bus.o_data !== 32'h0) + (bus.o_start !== 1'b0)
            + (bus.o_end !== 1'b0) + (bus.fifo_rd_en !== 2'b00);
    fq[0].delete();
    drive_inputs();
    rstn = 1'b1;
    #1;
    model_rr = 0;
  endtask

  task automatic test_single_packet();
    logic [33:0] ew [4];
    logic        vexp;
    for (int k = 0; k < 4; k++) ew[k] = {32'(k * 16), (k == 0), (k == 3)};
    clear_capture();
    push_pkt(0, 4, 32'h0, 1'(PORT_ID));
    checks++;
    if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL single_v0: got %b want 0", bus.o_valid); end
    for (int s = 1; s <= 6; s++) begin
      cycle();
      vexp = (s >= 2 && s <= 5);
      checks++;
      if (bus.o_valid !== vexp) begin
        errors++; $display("FAIL single_valid[%0d]: got %b want %b", s, bus.o_valid, vexp);
      end
      if (vexp) begin
        checks++;
        if ({bus.o_data, bus.o_start, bus.o_end} !== ew[s - 2]) begin
          errors++; $display("FAIL single_word[%0d]: got %h want %h", s - 2, {bus.o_data, bus.o_start, bus.o_end}, ew[s - 2]);
        end
      end
      if (s == 1) begin
        checks++;
        if (bus.fifo_rd_en !== 2'b01) begin errors++; $display("FAIL single_first_pop: got %b want 01", bus.fifo_rd_en); end
      end
    end
    checks++;
    if (fq[0].size() != 0 || underflow != 0) begin
      errors++; $display("FAIL single_drain: fifo left %0d underflow %0d want 0 0", fq[0].size(), underflow);
    end
    model_rr = 1;
  endtask

  task automatic test_round_robin();
    logic to;
    do_reset();
    push_pkt(0, 2, 32'h1000, 1'(PORT_ID));
    push_pkt(1, 2, 32'h2000, 1'(PORT_ID));
    push_pkt(0, 2, 32'h3000, 1'(PORT_ID));
    push_pkt(1, 2, 32'h4000, 1'(PORT_ID));
    build_expected();
    run_drain(200, 1'b0, to);
    checks++; if (to) begin errors++; $display("FAIL rr_timeout: drain did not complete"); end
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rr_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (k >= got_q.size() || got_q[k] !== exp_q[k]) begin
        errors++; $display("FAIL rr_word[%0d]: got %h want %h", k, (k < got_q.size()) ? got_q[k] : 34'h0, exp_q[k]);
      end
    end
    checks++;
    if (got_t.size() < 3 || got_t[1] - got_t[0] != 1 || got_t[2] - got_t[1] != 2) begin
      errors++; $display("FAIL rr_gap: word spacing not 1 then 2 cycles");
    end
    // A lone FIFO0 packet moves the pointer to 1, so FIFO1 must win the next simultaneous pair.
    push_pkt(0, 1, 32'h5000, 1'(PORT_ID));
    run_drain(50, 1'b0, to);
    clear_capture();
    push_pkt(0, 2, 32'h6000, 1'(PORT_ID));
    push_pkt(1, 2, 32'h7000, 1'(PORT_ID));
    run_drain(100, 1'b0, to);
    checks++;
    if (got_q.size() != 4 || got_q[0] !== {32'h7000, 1'b1, 1'b0}) begin
      errors++; $display("FAIL rr_ptr1_first: got %h want %h", (got_q.size() != 0) ? got_q[0] : 34'h0, {32'h7000, 1'b1, 1'b0});
    end
    model_rr = 0;
  endtask

  task automatic test_wrong_dest();
    clear_capture();
    push_pkt(0, 3, 32'h7100, ~1'(PORT_ID));
    for (int s = 0; s < 8; s++) begin
      cycle();
      checks++;
      if (bus.fifo_rd_en !== 2'b00 || bus.o_valid !== 1'b0) begin
        errors++; $display("FAIL wrong_dest[%0d]: rd_en %b valid %b want 00 0", s, bus.fifo_rd_en, bus.o_valid);
      end
    end
    fq[0].delete();
    drive_inputs();
  endtask

  task automatic test_stall();
    logic [31:0] held;
    logic to;
    clear_capture();
    bus.o_ready = 1'b1;
    push_pkt(0, 6, 32'h8000, 1'(PORT_ID));
    build_expected();
    repeat (3) cycle();
    bus.o_ready = 1'b0;
    #1;
    held = bus.o_data;
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (bus.fifo_rd_en !== 2'b00) begin errors++; $display("FAIL stall_rd_en[%0d]: got %b want 00", s, bus.fifo_rd_en); end
      cycle();
      checks++;
      if (bus.o_valid !== 1'b1 || bus.o_data !== held) begin
        errors++; $display("FAIL stall_hold[%0d]: got %h/%b want %h/1", s, bus.o_data, bus.o_valid, held);
      end
    end
    bus.o_ready = 1'b1;
    run_drain(100, 1'b0, to);
    checks++;
    if (to || got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL stall_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (k >= got_q.size() || got_q[k] !== exp_q[k]) begin
        errors++; $display("FAIL stall_word[%0d]: got %h want %h", k, (k < got_q.size()) ? got_q[k] : 34'h0, exp_q[k]);
      end
    end
  endtask

  task automatic test_underrun();
    logic [33:0] pw [5];
    int n;
    logic to;
    do_reset();
    bus.o_ready = 1'b1;
    for (int k = 0; k < 5; k++) pw[k] = {32'h9000 + 32'(k * 16), (k == 0), (k == 4)};
    fq[0].push_back(pw[0]);
    fq[0].push_back(pw[1]);
    push_pkt(1, 2, 32'hA000, 1'(PORT_ID));
    exp_q.delete();
    for (int k = 0; k < 5; k++) exp_q.push_back(pw[k]);
    for (int k = 0; k < 2; k++) exp_q.push_back(fq[1][k]);
    n = 0;
    while (fq[0].size() != 0 && n < 20) begin cycle(); n++; end
    checks++;
    if (fq[0].size() != 0) begin errors++; $display("FAIL underrun_pop: fifo0 left %0d want 0", fq[0].size()); end
    for (int s = 0; s < 4; s++) begin
      cycle();
      checks++;
      if (bus.fifo_rd_en !== 2'b00) begin errors++; $display("FAIL underrun_hold[%0d]: rd_en %b want 00", s, bus.fifo_rd_en); end
    end
    checks++;
    if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL underrun_gap: valid %b want 0", bus.o_valid); end
    for (int k = 2; k < 5; k++) fq[0].push_back(pw[k]);
    drive_inputs();
    run_drain(100, 1'b0, to);
    checks++;
    if (to || got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL underrun_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (k >= got_q.size() || got_q[k] !== exp_q[k]) begin
        errors++; $display("FAIL underrun_word[%0d]: got %h want %h", k, (k < got_q.size()) ? got_q[k] : 34'h0, exp_q[k]);
      end
    end
    checks++;
    if (got_t.size() < 3 || got_t[2] - got_t[1] <= 1) begin errors++; $display("FAIL underrun_valid_gap: no idle gap seen"); end
    model_rr = 0;
  endtask

  task automatic test_reset_mid_packet();
    clear_capture();
    bus.o_ready = 1'b1;
    push_pkt(0, 6, 32'hB000, 1'(PORT_ID));
    repeat (3) cycle();
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if (bus.o_valid !== 1'b0 || bus.o_data !== 32'h0 || bus.fifo_rd_en !== 2'b00) begin
      errors++; $display("FAIL rst_mid_async: valid %b data %h rd_en %b want 0 0 00", bus.o_valid, bus.o_data, bus.fifo_rd_en);
    end
    @(negedge clk);
    rstn = 1'b1;
    #1;
    for (int s = 0; s < 5; s++) begin
      cycle();
      checks++;
      if (bus.o_valid !== 1'b0 || bus.fifo_rd_en !== 2'b00) begin
        errors++; $display("FAIL rst_mid_idle[%0d]: valid %b rd_en %b want 0 00", s, bus.o_valid, bus.fifo_rd_en);
      end
    end
    fq[0].delete();
    drive_inputs();
    model_rr = 0;
  endtask

  task automatic test_random();
    logic to;
    int np;
    int bad;
    do_reset();
    for (int r = 0; r < 3; r++) begin
      clear_capture();
      for (int i = 0; i < N_IN; i++) begin
        np = $urandom_range(1, 4);
        for (int p = 0; p < np; p++) push_pkt(i, $urandom_range(1, 5), $urandom, 1'(PORT_ID));
      end
      build_expected();
      run_drain(3000, 1'b1, to);
      bus.o_ready = 1'b1;
      checks++;
      if (to || got_q.size() != exp_q.size()) begin
        errors++; $display("FAIL rand_count[%0d]: got %0d want %0d timeout %b", r, got_q.size(), exp_q.size(), to);
      end
      bad = 0;
      for (int k = 0; k < exp_q.size(); k++)
        if (k >= got_q.size() || got_q[k] !== exp_q[k]) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL rand_words[%0d]: %0d wrong words want 0", r, bad); end
      checks++;
      if (stall_bad != 0 || underflow != 0) begin
        errors++; $display("FAIL rand_protocol[%0d]: stall_bad %0d underflow %0d want 0 0", r, stall_bad, underflow);
      end
    end
  endtask

`ifdef ETH_OUT_ARB_PKT_CNT_EN
  task automatic test_pkt_cnt();
    logic to;
    do_reset();
    bus.o_ready = 1'b1;
    push_pkt(1, 2, 32'hC000, 1'(PORT_ID));
    push_pkt(1, 1, 32'hD000, 1'(PORT_ID));
    push_pkt(1, 3, 32'hE000, 1'(PORT_ID));
    run_drain(100, 1'b0, to);
    checks++;
    if (pkt_cnt[1] !== 16'd3) begin errors++; $display("FAIL pkt_cnt1: got %0d want 3", pkt_cnt[1]); end
    checks++;
    if (pkt_cnt[0] !== 16'd0) begin errors++; $display("FAIL pkt_cnt0: got %0d want 0", pkt_cnt[0]); end
  endtask
`endif

  initial begin
    rstn = 1'b0;
    bus.o_ready = 1'b1;
    bus.fifo_empty = '1;
    bus.fifo_rd_data = '0;
    test_reset();
    test_single_packet();
    test_round_robin();
    test_wrong_dest();
    test_stall();
    test_underrun();
    test_reset_mid_packet();
    test_random();
`ifdef ETH_OUT_ARB_PKT_CNT_EN
    test_pkt_cnt();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
